// File: rtl/indicator_controller.sv
// Turn-signal / hazard / brake lamp controller with synchronized button inputs,
// press-edge detection, a blink timer and optional auto-cancel after N blinks.
module indicator_controller #(
    parameter int unsigned HALF_PERIOD = 25000000,
    parameter int unsigned BLINK_LIMIT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_hazard,
    input  logic       brake,
    output logic       left_ind,
    output logic       right_ind,
    output logic       brake_light,
    output logic [1:0] mode,
    output logic [7:0] blink_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LEFT   = 2'b01,
        RIGHT  = 2'b10,
        HAZARD = 2'b11
    } state_t;

    localparam logic [31:0] TIMER_LAST = 32'(HALF_PERIOD - 1);

    logic [1:0] rst_sync;
    logic       rst_int_n;
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [2:0] prev;
    logic [2:0] press;
    logic       press_l;
    logic       press_r;
    logic       press_h;
    logic       auto_cancel;

    state_t      state;
    state_t      next_state;
    logic [31:0] timer;
    logic [31:0] next_timer;
    logic        phase;
    logic        next_phase;
    logic [7:0]  next_cnt;

    // Reset asserts immediately but releases only on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= {brake, btn_hazard, btn_right, btn_left};
            sync2 <= sync1;
            prev  <= sync2[2:0];
        end
    end

    assign press   = sync2[2:0] & ~prev;
    assign press_l = press[0] & ~press[1];
    assign press_r = press[1] & ~press[0];
    assign press_h = press[2];

    // Simultaneous left+right presses cancel each other; a press beats auto-cancel.
    always_comb begin
        auto_cancel = (BLINK_LIMIT != 0) && (blink_cnt == 8'(BLINK_LIMIT));
        next_state  = state;
        unique case (state)
            IDLE: begin
                if (press_h)      next_state = HAZARD;
                else if (press_l) next_state = LEFT;
                else if (press_r) next_state = RIGHT;
            end
            LEFT: begin
                if (press_h)          next_state = HAZARD;
                else if (press_l)     next_state = IDLE;
                else if (press_r)     next_state = RIGHT;
                else if (auto_cancel) next_state = IDLE;
            end
            RIGHT: begin
                if (press_h)          next_state = HAZARD;
                else if (press_r)     next_state = IDLE;
                else if (press_l)     next_state = LEFT;
                else if (auto_cancel) next_state = IDLE;
            end
            HAZARD: begin
                if (press_h) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase

        if (next_state != state) begin
            next_timer = '0;
            next_phase = (next_state != IDLE);
            next_cnt   = '0;
        end else if (state == IDLE) begin
            next_timer = '0;
            next_phase = 1'b0;
            next_cnt   = '0;
        end else if (timer == TIMER_LAST) begin
            next_timer = '0;
            next_phase = ~phase;
            next_cnt   = (phase && blink_cnt != 8'hFF) ? blink_cnt + 8'd1 : blink_cnt;
        end else begin
            next_timer = timer + 32'd1;
            next_phase = phase;
            next_cnt   = blink_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state       <= IDLE;
            timer       <= '0;
            phase       <= 1'b0;
            blink_cnt   <= '0;
            left_ind    <= 1'b0;
            right_ind   <= 1'b0;
            brake_light <= 1'b0;
        end else begin
            state       <= next_state;
            timer       <= next_timer;
            phase       <= next_phase;
            blink_cnt   <= next_cnt;
            left_ind    <= next_phase && (next_state == LEFT  || next_state == HAZARD);
            right_ind   <= next_phase && (next_state == RIGHT || next_state == HAZARD);
            brake_light <= sync2[3];
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_indicator_controller.sv
// Bench for indicator_controller: directed table, hand-written corner sequences and
// random stimulus, all compared against an age-based reference model of two instances.
module tb_indicator_controller;

    localparam int HP = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_hazard = 1'b0;
    logic       brake = 1'b0;

    logic       left_a, right_a, brake_a;
    logic [1:0] mode_a;
    logic [7:0] cnt_a;
    logic       left_b, right_b, brake_b;
    logic [1:0] mode_b;
    logic [7:0] cnt_b;

    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    indicator_controller #(.HALF_PERIOD(HP), .BLINK_LIMIT(3)) dut (
        .clk(clk), .rst_n(rst_n), .btn_left(btn_left), .btn_right(btn_right),
        .btn_hazard(btn_hazard), .brake(brake), .left_ind(left_a), .right_ind(right_a),
        .brake_light(brake_a), .mode(mode_a), .blink_cnt(cnt_a)
    );

    indicator_controller #(.HALF_PERIOD(HP), .BLINK_LIMIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .btn_left(btn_left), .btn_right(btn_right),
        .btn_hazard(btn_hazard), .brake(brake), .left_ind(left_b), .right_ind(right_b),
        .brake_light(brake_b), .mode(mode_b), .blink_cnt(cnt_b)
    );

    // Reference model: inputs history, and per instance the mode plus edges spent in it.
    typedef struct {
        bit l;
        bit r;
        bit h;
        bit b;
    } samp_t;

    samp_t hist[$];
    int    m_mode[2];
    int    m_age[2];
    int    lim[2];
    int    m_hold;
    bit    m_brake;

    function automatic int exp_cnt(int i);
        int n;
        if (m_mode[i] == 0) return 0;
        n = (m_age[i] + HP) / (2 * HP);
        return (n > 255) ? 255 : n;
    endfunction

    function automatic int exp_on(int i);
        return (m_mode[i] != 0 && ((m_age[i] / HP) % 2) == 0) ? 1 : 0;
    endfunction

    function automatic int exp_left(int i);
        return (m_mode[i] == 1 || m_mode[i] == 3) ? exp_on(i) : 0;
    endfunction

    function automatic int exp_right(int i);
        return (m_mode[i] == 2 || m_mode[i] == 3) ? exp_on(i) : 0;
    endfunction

    task automatic model_reset();
        samp_t z;
        z = '{0, 0, 0, 0};
        hist.delete();
        for (int k = 0; k < 4; k++) hist.push_back(z);
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0;
            m_age[i]  = 0;
        end
        m_hold  = 2;
        m_brake = 0;
    endtask

    task automatic model_step();
        samp_t s;
        bit pl, pr, ph, one_l, one_r;
        int nxt;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_hold > 0) begin
            m_hold--;
            return;
        end
        s = '{btn_left, btn_right, btn_hazard, brake};
        hist.push_back(s);
        void'(hist.pop_front());
        pl = hist[$-2].l && !hist[$-3].l;
        pr = hist[$-2].r && !hist[$-3].r;
        ph = hist[$-2].h && !hist[$-3].h;
        m_brake = hist[$-2].b;
        one_l = pl && !pr;
        one_r = pr && !pl;
        for (int i = 0; i < 2; i++) begin
            nxt = m_mode[i];
            case (m_mode[i])
                0: if (ph) nxt = 3; else if (one_l) nxt = 1; else if (one_r) nxt = 2;
                1: if (ph) nxt = 3; else if (one_l) nxt = 0; else if (one_r) nxt = 2;
                   else if (lim[i] != 0 && exp_cnt(i) == lim[i]) nxt = 0;
                2: if (ph) nxt = 3; else if (one_r) nxt = 0; else if (one_l) nxt = 1;
                   else if (lim[i] != 0 && exp_cnt(i) == lim[i]) nxt = 0;
                default: if (ph) nxt = 0;
            endcase
            if (nxt != m_mode[i]) begin
                m_mode[i] = nxt;
                m_age[i]  = 0;
            end else if (m_mode[i] != 0) begin
                m_age[i]++;
            end
        end
    endtask

    task automatic check(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic checkOutput(string tag);
        check({tag, " mode"},  int'(mode_a),  m_mode[0]);
        check({tag, " left"},  int'(left_a),  exp_left(0));
        check({tag, " right"}, int'(right_a), exp_right(0));
        check({tag, " brake"}, int'(brake_a), int'(m_brake));
        check({tag, " cnt"},   int'(cnt_a),   exp_cnt(0));
        check({tag, " mode0"},  int'(mode_b),  m_mode[1]);
        check({tag, " left0"},  int'(left_b),  exp_left(1));
        check({tag, " right0"}, int'(right_b), exp_right(1));
        check({tag, " brake0"}, int'(brake_b), int'(m_brake));
        check({tag, " cnt0"},   int'(cnt_b),   exp_cnt(1));
    endtask

    task automatic applyStimulus(bit rst, bit l, bit r, bit h, bit b);
        @(negedge clk);
        rst_n      = rst;
        btn_left   = l;
        btn_right  = r;
        btn_hazard = h;
        brake      = b;
        @(posedge clk);
        model_step();
        #1;
        checkOutput("model");
    endtask

    // One-cycle pulse, then wait until the edge at which the press takes effect.
    task automatic pressButton(bit l, bit r, bit h);
        bit b;
        b = brake;
        applyStimulus(1, l, r, h, b);
        applyStimulus(1, 0, 0, 0, b);
        applyStimulus(1, 0, 0, 0, b);
    endtask

    task automatic checkAllZero(string tag);
        check({tag, " mode"},  int'(mode_a),  0);
        check({tag, " left"},  int'(left_a),  0);
        check({tag, " right"}, int'(right_a), 0);
        check({tag, " brake"}, int'(brake_a), 0);
        check({tag, " cnt"},   int'(cnt_a),   0);
        check({tag, " mode0"}, int'(mode_b),  0);
        check({tag, " left0"}, int'(left_b),  0);
        check({tag, " right0"}, int'(right_b), 0);
    endtask

    typedef struct {
        bit l;
        bit r;
        bit h;
        bit b;
        int md;
        int li;
        int ri;
        int bl;
        int cnt;
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t mk(bit l, bit r, bit h, bit b, int md, int li, int ri, int bl, int cnt);
        vec_t v;
        v = '{l, r, h, b, md, li, ri, bl, cnt};
        return v;
    endfunction

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        lim[0] = 3;
        lim[1] = 0;

        // Left pulse with HALF_PERIOD=4, BLINK_LIMIT=3, brake pulse overlaid.
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 1, 1, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 1, 1, 1, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 1, 1, 1, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 1, 1, 1, 0, 1, 0);
        tbl[6]  = mk(0, 0, 0, 1, 1, 0, 0, 1, 1);
        tbl[7]  = mk(0, 0, 0, 1, 1, 0, 0, 1, 1);
        tbl[8]  = mk(0, 0, 0, 1, 1, 0, 0, 1, 1);
        tbl[9]  = mk(0, 0, 0, 0, 1, 0, 0, 1, 1);
        tbl[10] = mk(0, 0, 0, 0, 1, 1, 0, 1, 1);
        tbl[11] = mk(0, 0, 0, 0, 1, 1, 0, 0, 1);
        tbl[12] = mk(0, 0, 0, 0, 1, 1, 0, 0, 1);
        tbl[13] = mk(0, 0, 0, 0, 1, 1, 0, 0, 1);
        tbl[14] = mk(0, 0, 0, 0, 1, 0, 0, 0, 2);
        tbl[15] = mk(0, 0, 0, 0, 1, 0, 0, 0, 2);
        tbl[16] = mk(0, 0, 0, 0, 1, 0, 0, 0, 2);
        tbl[17] = mk(0, 0, 0, 0, 1, 0, 0, 0, 2);
        tbl[18] = mk(0, 0, 0, 0, 1, 1, 0, 0, 2);
        tbl[19] = mk(0, 0, 0, 0, 1, 1, 0, 0, 2);
        tbl[20] = mk(0, 0, 0, 0, 1, 1, 0, 0, 2);
        tbl[21] = mk(0, 0, 0, 0, 1, 1, 0, 0, 2);
        tbl[22] = mk(0, 0, 0, 0, 1, 0, 0, 0, 3);
        tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

        #1;
        rst_n = 1'b0;
        model_reset();
        #2;
        checkAllZero("reset");
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, 0);

        $display("[TB] directed table");
        for (int t = 0; t < 25; t++) begin
            applyStimulus(1, tbl[t].l, tbl[t].r, tbl[t].h, tbl[t].b);
            check($sformatf("tbl[%0d] mode", t),  int'(mode_a),  tbl[t].md);
            check($sformatf("tbl[%0d] left", t),  int'(left_a),  tbl[t].li);
            check($sformatf("tbl[%0d] right", t), int'(right_a), tbl[t].ri);
            check($sformatf("tbl[%0d] brake", t), int'(brake_a), tbl[t].bl);
            check($sformatf("tbl[%0d] cnt", t),   int'(cnt_a),   tbl[t].cnt);
        end

        $display("[TB] hazard override");
        pressButton(0, 0, 1);
        pressButton(0, 0, 1);
        pressButton(1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        pressButton(0, 0, 1);
        check("haz mode", int'(mode_a), 3);
        check("haz left", int'(left_a), 1);
        check("haz right", int'(right_a), 1);
        check("haz cnt", int'(cnt_a), 0);
        pressButton(1, 0, 0);
        check("haz ignores left", int'(mode_a), 3);
        pressButton(0, 0, 1);
        check("haz exit", int'(mode_a), 0);

        $display("[TB] left to right switch");
        pressButton(1, 0, 0);
        pressButton(0, 1, 0);
        check("switch mode", int'(mode_a), 2);
        check("switch right", int'(right_a), 1);
        check("switch left", int'(left_a), 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 0, 0);
            check("switch right on", int'(right_a), 1);
        end
        applyStimulus(1, 0, 0, 0, 0);
        check("switch right off", int'(right_a), 0);
        pressButton(0, 1, 0);
        check("right cancel", int'(mode_a), 0);
        pressButton(1, 1, 0);
        check("both ignored", int'(mode_a), 0);

        $display("[TB] brake during hazard");
        pressButton(0, 0, 1);
        applyStimulus(1, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 1);
        check("brake not yet", int'(brake_a), 0);
        applyStimulus(1, 0, 0, 0, 1);
        check("brake on", int'(brake_a), 1);
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 0, 1);
        check("brake steady", int'(brake_a), 1);
        check("brake haz mode", int'(mode_a), 3);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        check("brake hold", int'(brake_a), 1);
        applyStimulus(1, 0, 0, 0, 0);
        check("brake off", int'(brake_a), 0);
        pressButton(0, 0, 1);

        $display("[TB] reset mid-blink with right held");
        pressButton(0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0);
        check("pre-reset right", int'(right_a), 1);
        rst_n = 1'b0;
        btn_right = 1'b1;
        model_reset();
        #2;
        checkAllZero("async reset");
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 1, 0, 0);
        check("held after reset", int'(mode_a), 2);
        for (int i = 0; i < 20; i++) applyStimulus(1, 0, 1, 0, 0);
        check("held no repeat", int'(mode_b), 2);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0);

        $display("[TB] blink count saturation");
        pressButton(1, 0, 0);
        for (int i = 0; i < 2100; i++) applyStimulus(1, 0, 0, 0, 0);
        check("sat mode", int'(mode_b), 1);
        check("sat cnt", int'(cnt_b), 255);

        $display("[TB] random stimulus");
        for (int i = 0; i < 800; i++) begin
            applyStimulus(($urandom_range(0, 299) != 0),
                          ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 14) == 0),
                          ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/indicator_controller.md
INDICATOR_CONTROLLER -- requirements
Module: indicator_controller

Interface
REQ-001 Parameter HALF_PERIOD, default 25000000, lamp on/off half-period in clk cycles (0.5 s at 50 MHz); legal range 2..2^32-1.
REQ-002 Parameter BLINK_LIMIT, default 0, completed blinks before LEFT/RIGHT auto-cancel; 0 = never cancel; legal range 0..255.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 btn_left  input  1  left-turn request, asynchronous level, active-high.
REQ-006 btn_right  input  1  right-turn request, asynchronous level, active-high.
REQ-007 btn_hazard  input  1  hazard request, asynchronous level, active-high.
REQ-008 brake  input  1  brake request, asynchronous level, active-high.
REQ-009 left_ind  output  1  left lamp drive, registered.
REQ-010 right_ind  output  1  right lamp drive, registered.
REQ-011 brake_light  output  1  brake lamp drive, registered.
REQ-012 mode  output  2  current state: 00 IDLE, 01 LEFT, 10 RIGHT, 11 HAZARD.
REQ-013 blink_cnt  output  8  completed blinks in current state, saturating at 255.

Function
REQ-014 Each button and brake input SHALL pass through a 2-flop synchronizer; button inputs SHALL then be rising-edge detected (press event = synced high, previous synced low).
REQ-015 Lamp output change SHALL occur at the 3rd rising clk edge after the first edge sampling the button high; brake_light SHALL follow brake with the same 3-edge latency.
REQ-016 FSM states IDLE, LEFT, RIGHT, HAZARD; exactly one press event set is evaluated per cycle.
REQ-017 Priority: hazard press > left/right press; left and right press in the same cycle (without hazard) SHALL be ignored.
REQ-018 IDLE: left press -> LEFT; right press -> RIGHT; hazard press -> HAZARD.
REQ-019 LEFT: left press -> IDLE; right press -> RIGHT; hazard press -> HAZARD. RIGHT symmetric.
REQ-020 HAZARD: hazard press -> IDLE; left/right presses ignored.
REQ-021 On every state change: timer cleared to 0, phase set to ON (or OFF when entering IDLE), blink_cnt cleared to 0.
REQ-022 Timer: 32-bit, counts 0..HALF_PERIOD-1 in non-IDLE states; at HALF_PERIOD-1 wraps to 0 and phase toggles; held at 0 in IDLE.
REQ-023 blink_cnt SHALL increment on each ON->OFF phase toggle, saturating at 255.
REQ-024 When BLINK_LIMIT != 0 in LEFT/RIGHT and an ON->OFF toggle makes blink_cnt equal BLINK_LIMIT, next state SHALL be IDLE; a press event in the same cycle takes precedence over auto-cancel.
REQ-025 HAZARD SHALL ignore BLINK_LIMIT.
REQ-026 Outputs: LEFT -> left_ind=phase, right_ind=0; RIGHT -> right_ind=phase, left_ind=0; HAZARD -> both=phase; IDLE -> both 0.
REQ-027 Both lamps SHALL be in phase in HAZARD (never opposite).
REQ-028 brake_light SHALL be independent of FSM state and never gated by blink phase.
REQ-029 A button held high SHALL produce exactly one press event until released for at least one synced sample.

Reset
REQ-030 rst_n low SHALL asynchronously force: state IDLE, timer 0, phase OFF, blink_cnt 0, left_ind 0, right_ind 0, brake_light 0, mode 00, synchronizer and edge flops 0.
REQ-031 Reset mid-blink SHALL abort with no residual state; button held high through reset release SHALL produce one press event after release.
REQ-032 Deassertion SHALL be synchronous to clk (reset-release synchronizer internal).

Verification (HALF_PERIOD=4, BLINK_LIMIT=3 unless stated)
REQ-033 Left press pulse -> mode=01 after 3 edges, left_ind 1 for 4 cycles, 0 for 4, repeating; right_ind constant 0.
REQ-034 BLINK_LIMIT=3, left press -> after 3rd ON->OFF toggle blink_cnt=3 then mode=00, both lamps 0; BLINK_LIMIT=0 -> blinks continue past 255 with blink_cnt=255.
REQ-035 In LEFT, hazard press -> mode=11, both lamps 1 in same cycle, timer restart, blink_cnt=0; then left press ignored; hazard press -> mode=00.
REQ-036 In LEFT, right press mid-ON phase -> mode=10, right_ind 1 for full 4 cycles, left_ind 0 same cycle; simultaneous left+right press from IDLE -> mode stays 00.
REQ-037 brake=1 while in HAZARD -> brake_light 1 after 3 edges, steady, hazard blink unaffected; brake=0 -> brake_light 0 after 3 edges.
REQ-038 rst_n low during RIGHT ON phase -> all outputs 0 immediately (before next clk edge); release with btn_right held -> one press, mode=10, no repeat.
